// File: rtl/cpu_subsys_ctrl_if.sv
// Host bus bundle for cpu_subsys_ctrl.
// address_i, data_i, rd_wr_i (1 = write) in; data_o registered read data out.
interface cpu_subsys_ctrl_if #(
  parameter int AW = 15,
  parameter int DW = 16
);
  logic [AW-1:0] address_i;
  logic [DW-1:0] data_i;
  logic          rd_wr_i;
  logic [DW-1:0] data_o;

  modport master (
    output address_i, data_i, rd_wr_i,
    input  data_o
  );

  modport slave (
    input  address_i, data_i, rd_wr_i,
    output data_o
  );
endinterface

// File: rtl/cpu_subsys_ctrl.sv
// Soft-CPU subsystem control: host regs + RAM window, boot sequencer,
// vector remap, watchdog reboot, host/CPU write arbitration.
// Ports: clk_i, reset_i (async low), host bus (if), RAM port A,
// CPU bus in, cpu_reset_o/cpu_rdy_o/cpu_addr_trans_o/cpu_we_o/ram_b_we_o.
module cpu_subsys_ctrl #(
  parameter int unsigned BaseAddress   = 0,
  parameter int unsigned EndAddress    = 4099,
  parameter int unsigned address_width = 15,
  parameter int unsigned data_width    = 16,
  parameter int unsigned RAM_Size      = 4102,
  parameter int unsigned VectorCount   = 6,
  parameter int unsigned PowerOnHold   = 100,
  parameter int unsigned SettleCycles  = 3,
  parameter int unsigned WdogCycles    = 1000000,
  parameter logic [15:0] WdogKickAddr  = 16'h9F00
) (
  input  logic              clk_i,
  input  logic              reset_i,
  cpu_subsys_ctrl_if.slave  host,
  output logic [15:0]       ram_a_addr_o,
  output logic              ram_a_we_o,
  input  logic [7:0]        ram_a_dout_i,
  input  logic [15:0]       cpu_addr_i,
  input  logic              cpu_we_i,
  input  logic              io_claim_i,
  output logic              cpu_reset_o,
  output logic              cpu_rdy_o,
  output logic [15:0]       cpu_addr_trans_o,
  output logic              cpu_we_o,
  output logic              ram_b_we_o
);

  typedef enum logic [2:0] {
    HOLD   = 3'd0,
    RST    = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3
  } state_e;

  localparam int HoldW = $clog2(PowerOnHold + 1);
  localparam int SetW  = $clog2(SettleCycles + 1);
  localparam int WdW   = $clog2(WdogCycles + 1);

  localparam logic [HoldW-1:0] HoldLast = HoldW'(PowerOnHold - 1);
  localparam logic [SetW-1:0]  SetLast  = SetW'(SettleCycles - 1);
  localparam logic [WdW-1:0]   WdLoad   = WdW'(WdogCycles);
  localparam logic [31:0]      Span     = EndAddress - BaseAddress;
  localparam logic [16:0]      VecLo    = 17'h10000 - 17'(VectorCount);
  localparam logic [16:0]      RamTop   = 17'(RAM_Size);

  state_e           state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [SetW-1:0]  settle_q, settle_d;
  logic [WdW-1:0]   wdog_q, wdog_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic             trip_q, trip_d;
  logic [7:0]       boot_q, boot_d;
  logic             wen_q, wen_d;
  logic [7:0]       rd_q, rd_d;
  logic             ram_sel_q, ram_sel_d;

  logic [31:0] addr32, off;
  logic        in_win, is_ram, is_ctrl, is_stat, is_boot;
  logic        host_ram_we, collision;
  logic        soft_rst, pause, wen, running;
  logic        run_entry, kick, wd_active, wd_reload, expire;
  logic [16:0] vec_off;
  logic        unused_bits;

  // Out-of-range addresses below the base wrap to a huge offset,
  // so one unsigned compare covers both window bounds.
  assign addr32  = {{(32 - address_width){1'b0}}, host.address_i};
  assign off     = addr32 - BaseAddress;
  assign in_win  = off <= Span;
  assign is_ram  = in_win && off >= 32'd4;
  assign is_ctrl = in_win && off == 32'd0;
  assign is_stat = in_win && off == 32'd1;
  assign is_boot = in_win && off == 32'd2;

  assign host_ram_we  = is_ram & host.rd_wr_i;
  assign ram_a_we_o   = host_ram_we;
  assign ram_a_addr_o = is_ram ? 16'(off - 32'd4) : 16'd0;

  assign soft_rst = ctrl_q[0];
  assign pause    = ctrl_q[1];
  assign wen      = ctrl_q[2];
  assign running  = state_q == RUN;

  assign cpu_reset_o = (state_q == HOLD) | (state_q == RST);
  assign collision   = host_ram_we & cpu_we_i & running;
  assign cpu_rdy_o   = ~pause & ~cpu_reset_o & ~collision;
  assign cpu_we_o    = cpu_we_i & running & ~pause & ~collision;
  assign ram_b_we_o  = cpu_we_o & ~io_claim_i;

  assign vec_off = 17'h10000 - {1'b0, cpu_addr_i};
  assign cpu_addr_trans_o = ({1'b0, cpu_addr_i} >= VecLo)
                          ? 16'(RamTop - vec_off)
                          : cpu_addr_i;

  // Taken from state_q only, so expiry never feeds back into itself.
  assign run_entry = (state_q == SETTLE) && (settle_q == SetLast)
                   && !soft_rst;
  assign kick      = cpu_we_o && (cpu_addr_i == WdogKickAddr);
  assign wd_active = running & wen & ~pause;
  assign wd_reload = run_entry | (wen & ~wen_q) | kick;
  assign expire    = wd_active & ~wd_reload & (wdog_q <= WdW'(1));

  assign unused_bits = ^{host.data_i[data_width-1:4]};

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    settle_d = '0;
    unique case (state_q)
      HOLD: begin
        if (hold_q == HoldLast) state_d = RST;
        else hold_d = hold_q + HoldW'(1);
      end
      RST: begin
        if (!soft_rst) state_d = SETTLE;
      end
      SETTLE: begin
        if (settle_q == SetLast) state_d = RUN;
        else settle_d = settle_q + SetW'(1);
      end
      RUN: ;
      default: state_d = HOLD;
    endcase
    if (state_q != HOLD && (soft_rst || expire)) state_d = RST;
  end

  always_comb begin
    wdog_d = wdog_q;
    if (wd_reload) wdog_d = WdLoad;
    else if (wd_active)
      wdog_d = (wdog_q <= WdW'(1)) ? '0 : wdog_q - WdW'(1);
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    trip_d    = trip_q;
    boot_d    = boot_q + 8'(run_entry);
    wen_d     = wen;
    ram_sel_d = is_ram;
    if (is_ctrl && host.rd_wr_i) ctrl_d = host.data_i[2:0];
    if (expire) trip_d = 1'b1;
    else if (is_stat && host.rd_wr_i && host.data_i[3]) trip_d = 1'b0;
  end

  always_comb begin
    rd_d = '0;
    unique case (1'b1)
      is_ctrl: rd_d = {5'd0, ctrl_q};
      is_stat: rd_d = {3'd0, running, trip_q, state_q};
      is_boot: rd_d = boot_q;
      default: rd_d = '0;
    endcase
  end

  // RAM data is already a register output, so it is muxed in directly
  // to keep the same one-cycle latency as register reads.
  assign host.data_o = ram_sel_q
                     ? {{(data_width - 8){1'b0}}, ram_a_dout_i}
                     : {{(data_width - 8){1'b0}}, rd_q};

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= HOLD;
      hold_q    <= '0;
      settle_q  <= '0;
      wdog_q    <= '0;
      ctrl_q    <= '0;
      trip_q    <= 1'b0;
      boot_q    <= '0;
      wen_q     <= 1'b0;
      rd_q      <= '0;
      ram_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      settle_q  <= settle_d;
      wdog_q    <= wdog_d;
      ctrl_q    <= ctrl_d;
      trip_q    <= trip_d;
      boot_q    <= boot_d;
      wen_q     <= wen_d;
      rd_q      <= rd_d;
      ram_sel_q <= ram_sel_d;
    end
  end

endmodule

// File: tb/tb_cpu_subsys_ctrl.sv
// Self-checking bench for cpu_subsys_ctrl (WdogCycles = 50).
// Host-read expectations flow through a scoreboard queue.
module tb_cpu_subsys_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] ram_a_addr;
  logic        ram_a_we;
  logic [7:0]  ram_a_dout;
  logic [15:0] cpu_addr;
  logic        cpu_we, io_claim;
  logic        cpu_reset, cpu_rdy, cpu_we_q, ram_b_we;
  logic [15:0] cpu_trans;
  logic [7:0]  mem [0:8191];
  logic [15:0] exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  cpu_subsys_ctrl_if #(.AW(15), .DW(16)) hb ();

  cpu_subsys_ctrl #(.WdogCycles(50)) dut (
    .clk_i            (clk),
    .reset_i          (rst_n),
    .host             (hb.slave),
    .ram_a_addr_o     (ram_a_addr),
    .ram_a_we_o       (ram_a_we),
    .ram_a_dout_i     (ram_a_dout),
    .cpu_addr_i       (cpu_addr),
    .cpu_we_i         (cpu_we),
    .io_claim_i       (io_claim),
    .cpu_reset_o      (cpu_reset),
    .cpu_rdy_o        (cpu_rdy),
    .cpu_addr_trans_o (cpu_trans),
    .cpu_we_o         (cpu_we_q),
    .ram_b_we_o       (ram_b_we)
  );

  always @(posedge clk) begin
    if (ram_a_we) mem[ram_a_addr[12:0]] <= hb.data_i[7:0];
    ram_a_dout <= mem[ram_a_addr[12:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hw(input logic [14:0] a, input logic [15:0] d);
    hb.address_i = a;
    hb.data_i    = d;
    hb.rd_wr_i   = 1'b1;
    tick();
    hb.rd_wr_i   = 1'b0;
  endtask

  task automatic rd(input logic [14:0] a);
    hb.address_i = a;
    hb.rd_wr_i   = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cpu_we = 1'b1;
    repeat (3) tick();
    n_cmp++; if (cpu_reset !== 1'b1) begin n_bad++; $display("FAIL rst_cpu_reset got %b exp 1", cpu_reset); end
    n_cmp++; if (cpu_rdy !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_rdy got %b exp 0", cpu_rdy); end
    n_cmp++; if (cpu_we_q !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_we got %b exp 0", cpu_we_q); end
    n_cmp++; if (ram_b_we !== 1'b0) begin n_bad++; $display("FAIL rst_ram_b_we got %b exp 0", ram_b_we); end
    n_cmp++; if (hb.data_o !== 16'h0) begin n_bad++; $display("FAIL rst_data_o got %h exp 0", hb.data_o); end
    cpu_we = 1'b0;
  endtask

  task automatic test_boot();
    int hi = 0;
    bit low = 0;
    logic [15:0] e;
    rst_n = 1'b1;
    for (int i = 0; i < 300 && !low; i++) begin
      tick();
      if (cpu_reset) hi++;
      else low = 1;
    end
    n_cmp++; if (!low || hi != 100) begin n_bad++; $display("FAIL boot_hold cycles got %0d low %0d exp 100", hi, low); end
    cpu_addr = 16'h0100;
    cpu_we = 1'b1;
    #1;
    n_cmp++; if (cpu_we_q !== 1'b0) begin n_bad++; $display("FAIL settle_we got %b exp 0", cpu_we_q); end
    tick(); tick();
    n_cmp++; if (ram_b_we !== 1'b0) begin n_bad++; $display("FAIL settle_ramb got %b exp 0", ram_b_we); end
    tick();
    n_cmp++; if (cpu_we_q !== 1'b1 || ram_b_we !== 1'b1) begin n_bad++; $display("FAIL run_we got %b/%b exp 1/1", cpu_we_q, ram_b_we); end
    cpu_we = 1'b0;
    exp_q.push_back(16'h0013);
    rd(15'd1);
    e = exp_q.pop_front();
    n_cmp++; if (hb.data_o !== e) begin n_bad++; $display("FAIL boot_status got %h exp %h", hb.data_o, e); end
    exp_q.push_back(16'h0001);
    rd(15'd2);
    e = exp_q.pop_front();
    n_cmp++; if (hb.data_o !== e) begin n_bad++; $display("FAIL boot_count got %h exp %h", hb.data_o, e); end
  endtask

  task automatic test_soft_reset();
    logic [15:0] e;
    hw(15'd0, 16'h0001);
    tick();
    n_cmp++; if (cpu_reset !== 1'b1 || cpu_rdy !== 1'b0) begin n_bad++; $display("FAIL soft_rst got %b/%b exp 1/0", cpu_reset, cpu_rdy); end
    exp_q.push_back(16'h0001);
    rd(15'd1);
    e = exp_q.pop_front();
    n_cmp++; if (hb.data_o !== e) begin n_bad++; $display("FAIL soft_status got %h exp %h", hb.data_o, e); end
    exp_q.push_back(16'h0001);
    rd(15'd0);
    e = exp_q.pop_front();
    n_cmp++; if (hb.data_o !== e) begin n_bad++; $display("FAIL ctrl_read got %h exp %h", hb.data_o, e); end
    hw(15'd0, 16'h0000);
    tick();
    cpu_we = 1'b1;
    #1;
    n_cmp++; if (cpu_reset !== 1'b0 || ram_b_we !== 1'b0) begin n_bad++; $display("FAIL soft_settle got %b/%b exp 0/0", cpu_reset, ram_b_we); end
    exp_q.push_back(16'h0002);
    rd(15'd1);
    e = exp_q.pop_front();
    n_cmp++; if (hb.data_o !== e) begin n_bad++; $display("FAIL settle_status got %h exp %h", hb.data_o, e); end
    tick(); tick();
    n_cmp++; if (ram_b_we !== 1'b1) begin n_bad++; $display("FAIL soft_run_we got %b exp 1", ram_b_we); end
    cpu_we = 1'b0;
    exp_q.push_back(16'h0002);
    rd(15'd2);
    e = exp_q.pop_front();
    n_cmp++; if (hb.data_o !== e) begin n_bad++; $display("FAIL boot_count2 got %h exp %h", hb.data_o, e); end
  endtask

  task automatic test_translate();
    logic [15:0] ain [5] = '{16'hFFFC, 16'hFFF9, 16'hFFFF, 16'hFFFA, 16'h1234};
    logic [15:0] aex [5] = '{16'd4098, 16'hFFF9, 16'd4101, 16'd4096, 16'h1234};
    for (int i = 0; i < 5; i++) begin
      cpu_addr = ain[i];
      #1;
      n_cmp++; if (cpu_trans !== aex[i]) begin n_bad++; $display("FAIL xlate_%h got %h exp %h", ain[i], cpu_trans, aex[i]); end
    end
  endtask

  task automatic test_collision();
    logic [15:0] e;
    cpu_addr = 16'h0200;
    cpu_we = 1'b1;
    hb.address_i = 15'd14;
    hb.data_i = 16'hFF5A;
    hb.rd_wr_i = 1'b1;
    exp_q.push_back(16'h005A);
    #1;
    n_cmp++; if (cpu_rdy !== 1'b0 || ram_b_we !== 1'b0) begin n_bad++; $display("FAIL coll_stall got %b/%b exp 0/0", cpu_rdy, ram_b_we); end
    n_cmp++; if (ram_a_we !== 1'b1 || ram_a_addr !== 16'd10) begin n_bad++; $display("FAIL coll_porta got %b/%h exp 1/000a", ram_a_we, ram_a_addr); end
    tick();
    hb.rd_wr_i = 1'b0;
    #1;
    n_cmp++; if (cpu_rdy !== 1'b1 || ram_b_we !== 1'b1) begin n_bad++; $display("FAIL coll_retry got %b/%b exp 1/1", cpu_rdy, ram_b_we); end
    n_cmp++; if (cpu_trans !== 16'h0200) begin n_bad++; $display("FAIL coll_addr got %h exp 0200", cpu_trans); end
    cpu_we = 1'b0;
    hw(15'd4099, 16'h12A5);
    exp_q.push_back(16'h00A5);
    e = exp_q.pop_front();
    rd(15'd14);
    n_cmp++; if (hb.data_o !== e) begin n_bad++; $display("FAIL ram_rd14 got %h exp %h", hb.data_o, e); end
    e = exp_q.pop_front();
    rd(15'd4099);
    n_cmp++; if (hb.data_o !== e) begin n_bad++; $display("FAIL ram_rd_end got %h exp %h", hb.data_o, e); end
    hb.address_i = 15'd4100;
    #1;
    n_cmp++; if (ram_a_addr !== 16'd0) begin n_bad++; $display("FAIL unmapped_addr got %h exp 0", ram_a_addr); end
    exp_q.push_back(16'h0000);
    rd(15'd4100);
    e = exp_q.pop_front();
    n_cmp++; if (hb.data_o !== e) begin n_bad++; $display("FAIL unmapped_rd got %h exp %h", hb.data_o, e); end
    hw(15'd3, 16'h00FF);
    exp_q.push_back(16'h0000);
    rd(15'd3);
    e = exp_q.pop_front();
    n_cmp++; if (hb.data_o !== e) begin n_bad++; $display("FAIL reserved_rd got %h exp %h", hb.data_o, e); end
  endtask

  task automatic test_watchdog();
    int n = 0;
    logic [15:0] e;
    hw(15'd0, 16'h0004);
    // One cycle for the enable edge to reload, then 50 counting cycles.
    do begin
      tick();
      n++;
    end while (!cpu_reset && n < 200);
    n_cmp++; if (n != 51) begin n_bad++; $display("FAIL wdog_expire cycles got %0d exp 51", n); end
    exp_q.push_back(16'h0009);
    rd(15'd1);
    e = exp_q.pop_front();
    n_cmp++; if (hb.data_o !== e) begin n_bad++; $display("FAIL wdog_trip got %h exp %h", hb.data_o, e); end
    hw(15'd1, 16'h0008);
    exp_q.push_back(16'h0002);
    rd(15'd1);
    e = exp_q.pop_front();
    n_cmp++; if (hb.data_o !== e) begin n_bad++; $display("FAIL trip_clear got %h exp %h", hb.data_o, e); end
    hw(15'd0, 16'h0000);
    exp_q.push_back(16'h0003);
    rd(15'd2);
    e = exp_q.pop_front();
    n_cmp++; if (hb.data_o !== e) begin n_bad++; $display("FAIL boot_count3 got %h exp %h", hb.data_o, e); end
  endtask

  task automatic test_kick();
    bit saw = 0;
    logic [15:0] e;
    hw(15'd0, 16'h0004);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 40; i++) begin
        tick();
        if (cpu_reset) saw = 1;
      end
      cpu_addr = 16'h9F00;
      cpu_we = 1'b1;
      tick();
      cpu_we = 1'b0;
      if (cpu_reset) saw = 1;
    end
    n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL kick_reboot got %b exp 0", saw); end
    exp_q.push_back(16'h0013);
    rd(15'd1);
    e = exp_q.pop_front();
    n_cmp++; if (hb.data_o !== e) begin n_bad++; $display("FAIL kick_status got %h exp %h", hb.data_o, e); end
    hw(15'd0, 16'h0000);
  endtask

  task automatic test_io_pause();
    bit saw = 0;
    logic [15:0] e;
    cpu_addr = 16'h9000;
    cpu_we = 1'b1;
    io_claim = 1'b1;
    #1;
    n_cmp++; if (cpu_we_q !== 1'b1 || ram_b_we !== 1'b0) begin n_bad++; $display("FAIL io_claim got %b/%b exp 1/0", cpu_we_q, ram_b_we); end
    n_cmp++; if (cpu_trans !== 16'h9000) begin n_bad++; $display("FAIL io_addr got %h exp 9000", cpu_trans); end
    io_claim = 1'b0;
    cpu_we = 1'b0;
    hw(15'd0, 16'h0006);
    cpu_we = 1'b1;
    #1;
    n_cmp++; if (cpu_rdy !== 1'b0 || cpu_we_q !== 1'b0) begin n_bad++; $display("FAIL pause got %b/%b exp 0/0", cpu_rdy, cpu_we_q); end
    cpu_we = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (cpu_reset) saw = 1;
    end
    n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL pause_frozen got %b exp 0", saw); end
    exp_q.push_back(16'h0013);
    rd(15'd1);
    e = exp_q.pop_front();
    n_cmp++; if (hb.data_o !== e) begin n_bad++; $display("FAIL pause_status got %h exp %h", hb.data_o, e); end
    hw(15'd0, 16'h0000);
  endtask

  task automatic test_reset_mid();
    logic [15:0] e;
    hw(15'd0, 16'h0004);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (cpu_reset !== 1'b1 || cpu_rdy !== 1'b0 || hb.data_o !== 16'h0) begin n_bad++; $display("FAIL mid_rst got %b/%b/%h exp 1/0/0", cpu_reset, cpu_rdy, hb.data_o); end
    tick();
    rst_n = 1'b1;
    exp_q.push_back(16'h0000);
    rd(15'd0);
    e = exp_q.pop_front();
    n_cmp++; if (hb.data_o !== e) begin n_bad++; $display("FAIL mid_ctrl got %h exp %h", hb.data_o, e); end
    exp_q.push_back(16'h0000);
    rd(15'd1);
    e = exp_q.pop_front();
    n_cmp++; if (hb.data_o !== e) begin n_bad++; $display("FAIL mid_status got %h exp %h", hb.data_o, e); end
  endtask

  initial begin
    rst_n = 1'b0;
    hb.address_i = '0;
    hb.data_i = '0;
    hb.rd_wr_i = 1'b0;
    cpu_addr = '0;
    cpu_we = 1'b0;
    io_claim = 1'b0;
    test_reset();
    test_boot();
    test_soft_reset();
    test_translate();
    test_collision();
    test_watchdog();
    test_kick();
    test_io_pause();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
